// File: rtl/kernel_memory_pp.sv
// Ping-pong kernel weight store: packed-beat writer fills one bank while the reader streams the other.
// Optional KMEM_REPLAY_EN: banks stay loaded after a stream until an explicit rd_release pulse.
module kernel_memory_pp #(
   parameter int WORD_W = 32,
   parameter int PACK   = 4,
   parameter int DEPTH  = 64,
   parameter int ADDR_W = 6,
   parameter int CNT_W  = 3
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   wr_en,
   input  logic [PACK*WORD_W-1:0] wr_data,
   input  logic                   wr_last,
   input  logic [CNT_W-1:0]       wr_nwords,
   output logic                   wr_ready,
   input  logic                   rd_start,
`ifdef KMEM_REPLAY_EN
   input  logic                   rd_release,
`endif
   output logic                   rd_busy,
   output logic [WORD_W-1:0]      rd_data,
   output logic                   rd_valid,
   output logic                   rd_last,
   output logic [1:0]             bank_full,
   output logic                   err_overflow
);

   // One extra bit so the write pointer and lengths can reach DEPTH itself.
   localparam int PTR_W = ADDR_W + 1;

   logic [WORD_W-1:0] mem [2*DEPTH];

   logic              wb, rb;
   logic [PTR_W-1:0]  wp;
   logic [ADDR_W-1:0] rp;
   logic [PTR_W-1:0]  len [2];

   logic              wr_acc, rd_go, rd_end, release_go;
   logic [PTR_W-1:0]  n_eff, len_new;
   logic [PTR_W:0]    len_sum;
   logic [PTR_W-1:0]  lane_addr [PACK];
   logic [PACK-1:0]   lane_en, lane_ovf;
   logic [1:0]        set_mask, clr_mask;

   assign wr_ready = !bank_full[wb];
   assign wr_acc   = wr_en && wr_ready;
   assign rd_end   = ({1'b0, rp} == len[rb] - PTR_W'(1));

`ifdef KMEM_REPLAY_EN
   assign release_go = rd_release && !rd_busy;
`else
   assign release_go = 1'b0;
`endif
   assign rd_go = rd_start && !rd_busy && bank_full[rb] && !release_go;

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      n_eff    = (wr_nwords == '0) ? PTR_W'(PACK) : PTR_W'(wr_nwords);
      len_sum  = {1'b0, wp} + {1'b0, n_eff};
      len_new  = (len_sum > (PTR_W+1)'(DEPTH)) ? PTR_W'(DEPTH) : len_sum[PTR_W-1:0];
      lane_en  = '0;
      lane_ovf = '0;
      for (int i = 0; i < PACK; i++) begin
         lane_addr[i] = wp + PTR_W'(i);
         if (wr_acc && (!wr_last || (PTR_W'(i) < n_eff))) begin
            if (lane_addr[i] < PTR_W'(DEPTH)) lane_en[i]  = 1'b1;
            else                              lane_ovf[i] = 1'b1;
         end
      end
      set_mask = '0;
      clr_mask = '0;
      if (wr_acc && wr_last) set_mask[wb] = 1'b1;
`ifdef KMEM_REPLAY_EN
      if (release_go) clr_mask[rb] = 1'b1;
`else
      if (rd_busy && rd_end) clr_mask[rb] = 1'b1;
`endif
   end

   // NOTE: the weight RAM has no reset; its contents are don't-care until a kernel is loaded.
   always_ff @(posedge clk) begin
      for (int i = 0; i < PACK; i++)
         if (lane_en[i]) mem[{wb, lane_addr[i][ADDR_W-1:0]}] <= wr_data[i*WORD_W +: WORD_W];
   end

   // NOTE: all registered state uses non-blocking assignments so every reader sees pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         wb           <= 1'b0;
         rb           <= 1'b0;
         wp           <= '0;
         rp           <= '0;
         len          <= '{default: '0};
         bank_full    <= '0;
         err_overflow <= 1'b0;
         rd_busy      <= 1'b0;
         rd_valid     <= 1'b0;
         rd_last      <= 1'b0;
         rd_data      <= '0;
      end else begin
         bank_full <= (bank_full | set_mask) & ~clr_mask;
         if (|lane_ovf) err_overflow <= 1'b1;

         if (wr_acc) begin
            if (wr_last) begin
               len[wb] <= len_new;
               wb      <= ~wb;
               wp      <= '0;
            end else if (wp < PTR_W'(DEPTH)) begin
               wp <= wp + PTR_W'(PACK);
            end
         end

         rd_valid <= rd_busy;
         rd_last  <= rd_busy && rd_end;
         if (rd_busy) begin
            rd_data <= mem[{rb, rp}];
            rp      <= rp + ADDR_W'(1);
            if (rd_end) begin
               rd_busy <= 1'b0;
`ifndef KMEM_REPLAY_EN
               rb      <= ~rb;
`endif
            end
         end else if (rd_go) begin
            rd_busy <= 1'b1;
            rp      <= '0;
         end
`ifdef KMEM_REPLAY_EN
         if (release_go) rb <= ~rb;
`endif
      end
   end

endmodule

// File: tb/tb_kernel_memory_pp.sv
// Directed bench for kernel_memory_pp: table-driven loads plus hand-written stream sequences.
module tb_kernel_memory_pp;

   localparam int WORD_W = 32;
   localparam int PACK   = 4;
   localparam int DEPTH  = 64;
   localparam int ADDR_W = 6;
   localparam int CNT_W  = 3;
   localparam int DW     = PACK * WORD_W;

   logic              clk_tb = 1'b0;
   logic              rst;
   logic              wr_en;
   logic [DW-1:0]     wr_data;
   logic              wr_last;
   logic [CNT_W-1:0]  wr_nwords;
   logic              wr_ready;
   logic              rd_start;
   logic              rd_release;
   logic              rd_busy;
   logic [WORD_W-1:0] rd_data;
   logic              rd_valid;
   logic              rd_last;
   logic [1:0]        bank_full;
   logic              err_overflow;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk_tb = ~clk_tb;

   kernel_memory_pp #(
      .WORD_W(WORD_W), .PACK(PACK), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .CNT_W(CNT_W)
   ) dut (
      .clk(clk_tb),
      .rst(rst),
      .wr_en(wr_en),
      .wr_data(wr_data),
      .wr_last(wr_last),
      .wr_nwords(wr_nwords),
      .wr_ready(wr_ready),
      .rd_start(rd_start),
`ifdef KMEM_REPLAY_EN
      .rd_release(rd_release),
`endif
      .rd_busy(rd_busy),
      .rd_data(rd_data),
      .rd_valid(rd_valid),
      .rd_last(rd_last),
      .bank_full(bank_full),
      .err_overflow(err_overflow)
   );

   typedef struct {
      logic [DW-1:0]    data;
      logic             last;
      logic [CNT_W-1:0] nw;
      logic             exp_ready;
      logic [1:0]       exp_full;
   } wvec_t;

   wvec_t vec [10];

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_tb);
      #1;
   endtask

   function automatic logic [DW-1:0] pack_words(input int base);
      logic [DW-1:0] r;
      for (int i = 0; i < PACK; i++) r[i*WORD_W +: WORD_W] = WORD_W'(base + i);
      return r;
   endfunction

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic write_beat(input logic [DW-1:0] d, input logic last, input logic [CNT_W-1:0] nw);
      wr_en     = 1'b1;
      wr_data   = d;
      wr_last   = last;
      wr_nwords = nw;
      tick();
      wr_en     = 1'b0;
      wr_last   = 1'b0;
      wr_nwords = '0;
   endtask

   task automatic apply_vec(input int idx);
      write_beat(vec[idx].data, vec[idx].last, vec[idx].nw);
      check($sformatf("vec%0d_ready", idx), wr_ready, vec[idx].exp_ready);
      check($sformatf("vec%0d_full", idx), bank_full, vec[idx].exp_full);
   endtask

   // Pulses rd_start for one edge and checks it was accepted.
   task automatic start_stream(input string name);
      rd_start = 1'b1;
      tick();
      rd_start = 1'b0;
      check({name, "_busy_on_start"}, rd_busy, 1'b1);
      check({name, "_valid_on_start"}, rd_valid, 1'b0);
   endtask

   // Expects word i = base+i on each of len consecutive cycles; rd_start is raised
   // in the cycle showing word start_at-1 (start_at == len means with rd_last).
   task automatic expect_stream(input string name, input int base, input int len, input int start_at);
      for (int i = 0; i < len; i++) begin
         rd_start = (i == start_at) && (i != 0);
         tick();
         check($sformatf("%s_valid%0d", name, i), rd_valid, 1'b1);
         check($sformatf("%s_data%0d", name, i), rd_data, WORD_W'(base + i));
         check($sformatf("%s_last%0d", name, i), rd_last, (i == len - 1));
      end
      rd_start = (start_at == len);
   endtask

   initial begin
      rst = 1'b1; wr_en = 1'b0; wr_data = '0; wr_last = 1'b0; wr_nwords = '0;
      rd_start = 1'b0; rd_release = 1'b0;

      // Test-1 kernel: words 1..12 packed, last beat keeps only word 9.
      vec[0] = '{pack_words(1),     1'b0, 3'd0, 1'b1, 2'b00};
      vec[1] = '{pack_words(5),     1'b0, 3'd0, 1'b1, 2'b00};
      vec[2] = '{pack_words(9),     1'b1, 3'd1, 1'b1, 2'b01};
      // Kernel A into bank0, kernel B into bank1, then a beat that must be ignored.
      vec[3] = '{pack_words('h100), 1'b0, 3'd0, 1'b1, 2'b00};
      vec[4] = '{pack_words('h104), 1'b0, 3'd0, 1'b1, 2'b00};
      vec[5] = '{pack_words('h108), 1'b1, 3'd1, 1'b1, 2'b01};
      vec[6] = '{pack_words('h200), 1'b0, 3'd0, 1'b1, 2'b01};
      vec[7] = '{pack_words('h204), 1'b0, 3'd0, 1'b1, 2'b01};
      vec[8] = '{pack_words('h208), 1'b1, 3'd1, 1'b0, 2'b11};
      vec[9] = '{pack_words('hDEA0), 1'b1, 3'd0, 1'b0, 2'b11};

      tick();
      tick();
      check("rst_wr_ready", wr_ready, 1'b1);
      check("rst_rd_busy", rd_busy, 1'b0);
      check("rst_rd_valid", rd_valid, 1'b0);
      check("rst_rd_last", rd_last, 1'b0);
      check("rst_rd_data", rd_data, 0);
      check("rst_bank_full", bank_full, 2'b00);
      check("rst_err_overflow", err_overflow, 1'b0);
      rst = 1'b0;

`ifndef KMEM_REPLAY_EN
      // Test 1: basic 9-word kernel.
      for (int i = 0; i < 3; i++) apply_vec(i);
      start_stream("t1");
      expect_stream("t1", 1, 9, -1);
      check("t1_busy_end", rd_busy, 1'b0);
      check("t1_full_end", bank_full, 2'b00);
      check("t1_ready_end", wr_ready, 1'b1);

      // Test 2: both banks loaded, blocked write, back-to-back streams.
      do_reset();
      for (int i = 3; i < 10; i++) apply_vec(i);
      check("t2_no_ovf", err_overflow, 1'b0);
      start_stream("t2a");
      expect_stream("t2a", 'h100, 9, 9);
      check("t2_full_after_a", bank_full, 2'b10);
      check("t2_ready_after_a", wr_ready, 1'b1);
      tick();
      rd_start = 1'b0;
      check("t2b_busy_on_start", rd_busy, 1'b1);
      expect_stream("t2b", 'h200, 9, -1);
      check("t2_full_end", bank_full, 2'b00);

      // Test 3: overflow past DEPTH, wr_nwords=0 meaning PACK.
      do_reset();
      for (int b = 0; b < DEPTH / PACK; b++) write_beat(pack_words('h1000 + b * PACK), 1'b0, 3'd0);
      check("t3_no_ovf_at_depth", err_overflow, 1'b0);
      write_beat(pack_words('h1000 + DEPTH), 1'b0, 3'd0);
      check("t3_ovf_set", err_overflow, 1'b1);
      write_beat(pack_words('h2000), 1'b1, 3'd0);
      check("t3_ovf_sticky", err_overflow, 1'b1);
      check("t3_full", bank_full, 2'b01);
      start_stream("t3");
      expect_stream("t3", 'h1000, DEPTH, -1);
      tick();
      check("t3_no_extra_word", rd_valid, 1'b0);
      check("t3_full_end", bank_full, 2'b00);
      check("t3_ovf_after_read", err_overflow, 1'b1);

      // Test 4: start with empty banks, then start while busy.
      do_reset();
      rd_start = 1'b1;
      tick();
      rd_start = 1'b0;
      check("t4_empty_busy", rd_busy, 1'b0);
      tick();
      check("t4_empty_valid", rd_valid, 1'b0);
      check("t4_empty_busy2", rd_busy, 1'b0);
      for (int i = 0; i < 3; i++) apply_vec(i);
      start_stream("t4");
      expect_stream("t4", 1, 9, 3);
      check("t4_busy_end", rd_busy, 1'b0);
      begin
         int cnt = 0;
         for (int i = 0; i < 4; i++) begin
            tick();
            if (rd_valid || rd_busy) cnt++;
         end
         check("t4_no_restart", cnt, 0);
      end
      check("t4_full_end", bank_full, 2'b00);

      // Test 5: reset in the middle of a stream.
      do_reset();
      for (int i = 0; i < 3; i++) apply_vec(i);
      start_stream("t5");
      for (int i = 0; i < 3; i++) begin
         tick();
         check($sformatf("t5_data%0d", i), rd_data, WORD_W'(1 + i));
      end
      rst = 1'b1;
      tick();
      check("t5_valid", rd_valid, 1'b0);
      check("t5_busy", rd_busy, 1'b0);
      check("t5_full", bank_full, 2'b00);
      check("t5_ready", wr_ready, 1'b1);
      rst = 1'b0;
      begin
         int cnt = 0;
         for (int i = 0; i < 12; i++) begin
            tick();
            if (rd_last || rd_valid) cnt++;
         end
         check("t5_no_last", cnt, 0);
      end
`else
      // Test 6: replay the same kernel twice, then release it.
      for (int i = 0; i < 3; i++) apply_vec(i);
      start_stream("t6a");
      expect_stream("t6a", 1, 9, -1);
      check("t6_full_after_a", bank_full, 2'b01);
      tick();
      start_stream("t6b");
      expect_stream("t6b", 1, 9, -1);
      check("t6_full_after_b", bank_full, 2'b01);
      rd_release = 1'b1;
      tick();
      rd_release = 1'b0;
      check("t6_full_released", bank_full, 2'b00);
      write_beat(pack_words('h300), 1'b0, 3'd0);
      write_beat(pack_words('h304), 1'b1, 3'd2);
      check("t6_full_bank1", bank_full, 2'b10);
      start_stream("t6c");
      expect_stream("t6c", 'h300, 6, -1);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
